// File: rtl/fetch_queue_pkg.sv
// Shared fetch/decode types plus the fetch queue defaults.
// Holds the Inst_PC lane types, the invalid-lane constant and small lane helpers.
package fetch_queue_pkg;

  typedef enum logic {
    INVALID = 1'b0,
    VALID   = 1'b1
  } valid_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    valid_e      is_valid;
  } Inst_PC;

  typedef struct packed {
    Inst_PC A;
    Inst_PC B;
  } Inst_PC_N;

  localparam int FETCHQ_DEPTH = 8;

  localparam Inst_PC INVALID_INST_PC = '{pc: 32'h0000_0000, instr: 32'h0000_0000, is_valid: INVALID};

  // Number of lanes in a pair that carry a real instruction.
  function automatic logic [1:0] lane_count(input Inst_PC_N p);
    return {1'b0, p.A.is_valid == VALID} + {1'b0, p.B.is_valid == VALID};
  endfunction

  // Decode may request 3; the queue never hands out more than two per cycle.
  function automatic logic [1:0] clamp_pop(input logic [1:0] req);
    return (req == 2'd3) ? 2'd2 : req;
  endfunction

endpackage

// File: rtl/fetch_queue_perf.sv
// Saturating stall-cycle counter for the fetch queue (used with FETCHQ_PERF_EN).
module fetch_queue_perf (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  output logic [31:0] stall_cycles
);

  // Count blocked fetch cycles; holds at all-ones, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= 32'h0000_0000;
    end else if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end else begin
      stall_cycles <= stall_cycles;
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Dual-lane compacting instruction fetch queue between fetch and the dual decoder.
// Optional stall counter port stall_cycles is enabled by defining FETCHQ_PERF_EN.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FETCHQ_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  input  Inst_PC_N               in_pair,
  output logic                   in_ready,
  input  logic [1:0]             pop_cnt,
  output Inst_PC_N               out_pair,
  output logic [$clog2(DEPTH):0] count
`ifdef FETCHQ_PERF_EN
  ,
  output logic [31:0]            stall_cycles
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  Inst_PC          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_b;
  logic [PW-1:0]   rd_b;
  logic            a_in;
  logic            b_in;
  logic            push_en;
  logic [1:0]      push_n;
  logic [1:0]      pop_req;
  logic [1:0]      pop_n;

  assign in_ready = (DEPTH_C - count) >= CW'(2);

  // Push/pop amounts; a lone B lane lands on wr_ptr so the queue stays dense.
  always_comb begin
    a_in    = in_pair.A.is_valid == VALID;
    b_in    = in_pair.B.is_valid == VALID;
    push_en = in_valid && in_ready;
    push_n  = push_en ? lane_count(in_pair) : 2'd0;
    wr_b    = a_in ? (wr_ptr + PW'(1)) : wr_ptr;
    rd_b    = rd_ptr + PW'(1);
    pop_req = clamp_pop(pop_cnt);
    if ({{(CW-2){1'b0}}, pop_req} > count) begin
      pop_n = count[1:0];
    end else begin
      pop_n = pop_req;
    end
  end

  // Entry storage; contents are only observed through count-gated lanes, so no reset.
  always_ff @(posedge clk) begin
    if (push_en && !flush) begin
      if (a_in) begin
        mem[wr_ptr] <= in_pair.A;
      end
      if (b_in) begin
        mem[wr_b] <= in_pair.B;
      end
    end
  end

  // Pointers and occupancy; flush outranks any same-cycle push or pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push_n);
      rd_ptr <= rd_ptr + PW'(pop_n);
      count  <= count + CW'(push_n) - CW'(pop_n);
    end
  end

  // Oldest two entries to decode; lanes without a backing entry read as invalid.
  always_comb begin
    if (count >= CW'(1)) begin
      out_pair.A = mem[rd_ptr];
    end else begin
      out_pair.A = INVALID_INST_PC;
    end
    if (count >= CW'(2)) begin
      out_pair.B = mem[rd_b];
    end else begin
      out_pair.B = INVALID_INST_PC;
    end
  end

`ifdef FETCHQ_PERF_EN
  logic stall;
  assign stall = in_valid && !in_ready;

  fetch_queue_perf u_perf (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .stall_cycles (stall_cycles)
  );
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, corner sequences, random vs. queue model.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int D = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic       in_valid;
  Inst_PC_N   in_pair;
  logic       in_ready;
  logic [1:0] pop_cnt;
  Inst_PC_N   out_pair;
  logic [3:0] count;
`ifdef FETCHQ_PERF_EN
  logic [31:0] stall_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  fetch_queue #(.DEPTH(D)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_pair  (in_pair),
    .in_ready (in_ready),
    .pop_cnt  (pop_cnt),
    .out_pair (out_pair),
    .count    (count)
`ifdef FETCHQ_PERF_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic        iv;
    logic        a_v;
    logic [31:0] a_pc;
    logic        b_v;
    logic [31:0] b_pc;
    logic [1:0]  pop;
    logic [3:0]  e_count;
    logic        e_ready;
    logic        ea_v;
    logic [31:0] ea_pc;
    logic        eb_v;
    logic [31:0] eb_pc;
  } vec_t;

  vec_t vecs[16];

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    if (pc == 32'h0000_0000) return 32'h0050_0093;
    else if (pc == 32'h0000_0004) return 32'h00A0_0113;
    else return pc ^ 32'hDEAD_0013;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input int e_cnt, input logic e_rdy,
                         input logic ea_v, input logic [31:0] ea_pc,
                         input logic eb_v, input logic [31:0] eb_pc);
    chk({tag, " count"}, 32'(count), 32'(e_cnt));
    chk({tag, " in_ready"}, 32'(in_ready), 32'(e_rdy));
    chk({tag, " A.valid"}, 32'(out_pair.A.is_valid == VALID), 32'(ea_v));
    chk({tag, " A.pc"}, out_pair.A.pc, ea_v ? ea_pc : 32'h0);
    chk({tag, " A.instr"}, out_pair.A.instr, ea_v ? instr_of(ea_pc) : 32'h0);
    chk({tag, " B.valid"}, 32'(out_pair.B.is_valid == VALID), 32'(eb_v));
    chk({tag, " B.pc"}, out_pair.B.pc, eb_v ? eb_pc : 32'h0);
    chk({tag, " B.instr"}, out_pair.B.instr, eb_v ? instr_of(eb_pc) : 32'h0);
  endtask

  // Drive one cycle of inputs, let the edge pass, return 1 time unit after it.
  task automatic step(input logic fl, input logic iv, input logic av, input logic [31:0] apc,
                      input logic bv, input logic [31:0] bpc, input logic [1:0] pc_);
    flush             = fl;
    in_valid          = iv;
    in_pair.A.is_valid = av ? VALID : INVALID;
    in_pair.A.pc       = apc;
    in_pair.A.instr    = instr_of(apc);
    in_pair.B.is_valid = bv ? VALID : INVALID;
    in_pair.B.pc       = bpc;
    in_pair.B.instr    = instr_of(bpc);
    pop_cnt           = pc_;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 2'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    idle();
    reset = 1'b0;
    idle();
  endtask

  logic [31:0] q[$];
  logic [31:0] next_pc;

  initial begin
    reset    = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b0;
    in_pair  = '0;
    pop_cnt  = 2'd0;
    #2;
    chk_out("reset", 0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
`ifdef FETCHQ_PERF_EN
    chk("reset stall_cycles", stall_cycles, 32'h0);
`endif
    do_reset();

    // fl iv a_v a_pc b_v b_pc pop | count ready A(v,pc) B(v,pc)
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 32'h00, 1'b1, 32'h04, 2'd0, 4'd2, 1'b1, 1'b1, 32'h00, 1'b1, 32'h04};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00, 2'd2, 4'd0, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'hBAD0, 1'b1, 32'h08, 2'd0, 4'd1, 1'b1, 1'b1, 32'h08, 1'b0, 32'h00};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00, 2'd2, 4'd0, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00, 2'd3, 4'd0, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 32'h00, 1'b1, 32'h04, 2'd0, 4'd2, 1'b1, 1'b1, 32'h00, 1'b1, 32'h04};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0C, 2'd0, 4'd4, 1'b1, 1'b1, 32'h00, 1'b1, 32'h04};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h14, 2'd0, 4'd6, 1'b1, 1'b1, 32'h00, 1'b1, 32'h04};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 32'h18, 1'b1, 32'h1C, 2'd0, 4'd8, 1'b0, 1'b1, 32'h00, 1'b1, 32'h04};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 32'h20, 1'b1, 32'h24, 2'd0, 4'd8, 1'b0, 1'b1, 32'h00, 1'b1, 32'h04};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00, 2'd2, 4'd6, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0C};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00, 2'd1, 4'd5, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h10};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 32'h20, 1'b1, 32'h24, 2'd1, 4'd6, 1'b1, 1'b1, 32'h10, 1'b1, 32'h14};
    vecs[13] = '{1'b1, 1'b1, 1'b1, 32'h28, 1'b1, 32'h2C, 2'd2, 4'd0, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 32'h30, 1'b0, 32'hBAD4, 2'd0, 4'd1, 1'b1, 1'b1, 32'h30, 1'b0, 32'h00};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 32'h34, 1'b1, 32'h38, 2'd3, 4'd2, 1'b1, 1'b1, 32'h34, 1'b1, 32'h38};

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].fl, vecs[i].iv, vecs[i].a_v, vecs[i].a_pc, vecs[i].b_v, vecs[i].b_pc, vecs[i].pop);
      chk_out($sformatf("vec%0d", i), int'(vecs[i].e_count), vecs[i].e_ready,
              vecs[i].ea_v, vecs[i].ea_pc, vecs[i].eb_v, vecs[i].eb_pc);
    end

    // Asynchronous reset in the middle of a cycle with five entries queued.
    do_reset();
    step(1'b0, 1'b1, 1'b1, 32'h00, 1'b1, 32'h04, 2'd0);
    step(1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0C, 2'd0);
    step(1'b0, 1'b1, 1'b1, 32'h10, 1'b0, 32'h14, 2'd0);
    chk_out("pre-reset", 5, 1'b1, 1'b1, 32'h00, 1'b1, 32'h04);
    flush = 1'b0; in_valid = 1'b0; pop_cnt = 2'd0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_out("async reset", 0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle();

    // Steady push-2/pop-2 across three pointer wraps.
    step(1'b0, 1'b1, 1'b1, 32'h00, 1'b1, 32'h04, 2'd0);
    step(1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0C, 2'd0);
    for (int k = 1; k <= 12; k++) begin
      step(1'b0, 1'b1, 1'b1, 32'(8 * k + 8), 1'b1, 32'(8 * k + 12), 2'd2);
      chk_out($sformatf("wrap%0d", k), 4, 1'b1, 1'b1, 32'(8 * k), 1'b1, 32'(8 * k + 4));
    end

    // Fill, block three pushes, then flush alongside push and pop at count 6.
    do_reset();
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b1, 32'(8 * k), 1'b1, 32'(8 * k + 4), 2'd0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b1, 32'h20, 1'b1, 32'h24, 2'd0);
    chk_out("blocked", 8, 1'b0, 1'b1, 32'h00, 1'b1, 32'h04);
`ifdef FETCHQ_PERF_EN
    chk("stall_cycles after block", stall_cycles, 32'd3);
`endif
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 2'd2);
    chk_out("pre-flush", 6, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0C);
    step(1'b1, 1'b1, 1'b1, 32'h28, 1'b1, 32'h2C, 2'd2);
    chk_out("flush", 0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
`ifdef FETCHQ_PERF_EN
    chk("stall_cycles after flush", stall_cycles, 32'd3);
`endif
    step(1'b0, 1'b1, 1'b1, 32'h40, 1'b1, 32'h44, 2'd0);
    chk_out("post-flush push", 2, 1'b1, 1'b1, 32'h40, 1'b1, 32'h44);

    // Random traffic against a plain FIFO model.
    do_reset();
    q.delete();
    next_pc = 32'h1000;
    for (int c = 0; c < 400; c++) begin
      logic fl, iv, av, bv;
      logic [1:0] pr;
      logic [31:0] apc, bpc;
      int pop_n, free;
      fl  = ($urandom_range(0, 19) == 0);
      iv  = ($urandom_range(0, 3) != 0);
      av  = $urandom_range(0, 1) == 1;
      bv  = $urandom_range(0, 1) == 1;
      pr  = 2'($urandom_range(0, 3));
      apc = next_pc;
      bpc = next_pc + 32'd4;
      next_pc = next_pc + 32'd8;
      free = D - q.size();
      if (fl) begin
        q.delete();
      end else begin
        pop_n = (pr == 2'd3) ? 2 : int'(pr);
        if (pop_n > q.size()) pop_n = q.size();
        for (int p = 0; p < pop_n; p++) void'(q.pop_front());
        if (iv && free >= 2) begin
          if (av) q.push_back(apc);
          if (bv) q.push_back(bpc);
        end
      end
      step(fl, iv, av, apc, bv, bpc, pr);
      chk_out($sformatf("rand%0d", c), q.size(), (D - q.size()) >= 2,
              q.size() >= 1, (q.size() >= 1) ? q[0] : 32'h0,
              q.size() >= 2, (q.size() >= 2) ? q[1] : 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
